// File: rtl/link_pkg.sv
// Shared encodings and map geometry defaults for the player link_control slice.
package link_pkg;

  typedef enum logic [2:0] {
    S_RESET     = 3'd0,
    S_INIT      = 3'd1,
    S_DRAW_MAP  = 3'd2,
    S_DRAW_CHAR = 3'd3,
    S_WAIT      = 3'd4,
    S_DECIDE    = 3'd5,
    S_CMD       = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    UP    = 2'b00,
    DOWN  = 2'b01,
    LEFT  = 2'b10,
    RIGHT = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    CMD_IDLE   = 2'd0,
    CMD_ATTACK = 2'd1,
    CMD_MOVE   = 2'd2
  } cmd_t;

  localparam int MAP_W_DEF  = 256;
  localparam int MAP_H_DEF  = 176;
  localparam int SPRITE_DEF = 16;
  localparam int CNT_W      = 4;

endpackage

// File: rtl/link_frame_pacer.sv
// Frame pending flag plus move-rate and attack-lockout counters; all state updates on the
// cycle that enters DECIDE (load_lock excepted). Optional LINK_CTRL_OVERRUN_EN adds overrun_cnt.
module link_frame_pacer
  import link_pkg::*;
#(
  parameter int MOVE_DIV      = 2,
  parameter int ATTACK_FRAMES = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       armed,
  input  logic       frame_tick,
  input  logic       decide,
  input  logic       load_lock,
`ifdef LINK_CTRL_OVERRUN_EN
  output logic [7:0] overrun_cnt,
`endif
  output logic       pending,
  output logic       move_ok,
  output logic       locked
);

  logic             tick_in;
  logic             pending_q, pending_d;
  logic             move_ok_q, move_ok_d;
  logic             locked_q, locked_d;
  logic [CNT_W-1:0] move_cnt_q, move_cnt_d;
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;

  assign tick_in = armed && frame_tick;

  // move_ok/locked capture the counters before this visit's update so DECIDE sees them.
  always_comb begin
    pending_d  = pending_q;
    move_ok_d  = move_ok_q;
    locked_d   = locked_q;
    move_cnt_d = move_cnt_q;
    lock_cnt_d = lock_cnt_q;
    if (decide) begin
      pending_d  = 1'b0;
      move_ok_d  = (move_cnt_q == '0);
      locked_d   = (lock_cnt_q != '0);
      move_cnt_d = (move_cnt_q == CNT_W'(MOVE_DIV - 1)) ? '0 : move_cnt_q + 1'b1;
      if (lock_cnt_q != '0) lock_cnt_d = lock_cnt_q - 1'b1;
    end
    if (tick_in) pending_d = 1'b1;
    if (load_lock) lock_cnt_d = CNT_W'(ATTACK_FRAMES);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pending_q  <= 1'b0;
      move_ok_q  <= 1'b0;
      locked_q   <= 1'b0;
      move_cnt_q <= '0;
      lock_cnt_q <= '0;
    end else begin
      pending_q  <= pending_d;
      move_ok_q  <= move_ok_d;
      locked_q   <= locked_d;
      move_cnt_q <= move_cnt_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  assign pending = pending_q;
  assign move_ok = move_ok_q;
  assign locked  = locked_q;

`ifdef LINK_CTRL_OVERRUN_EN
  logic [7:0] overrun_q, overrun_d;

  always_comb begin
    overrun_d = overrun_q;
    if (tick_in && pending_q && !decide && (overrun_q != 8'hFF)) overrun_d = overrun_q + 8'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) overrun_q <= 8'd0;
    else       overrun_q <= overrun_d;
  end

  assign overrun_cnt = overrun_q;
`endif

endmodule

// File: rtl/link_control.sv
// Player game-loop FSM: one-hot registered strobes, map/char redraw handshakes, one command
// per frame 3 cycles after a tick seen in WAIT. Optional LINK_CTRL_OVERRUN_EN exposes overrun_cnt.
module link_control
  import link_pkg::*;
#(
  parameter int MOVE_DIV      = 2,
  parameter int ATTACK_FRAMES = 8,
  parameter int MAP_W         = MAP_W_DEF,
  parameter int MAP_H         = MAP_H_DEF,
  parameter int SPRITE        = SPRITE_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_attack,
  input  logic       frame_tick,
  input  logic [7:0] link_x,
  input  logic [7:0] link_y,
  input  logic       map_done,
  input  logic       char_done,
  output logic       init,
  output logic       idle,
  output logic       attack,
  output logic       move_up,
  output logic       move_down,
  output logic       move_left,
  output logic       move_right,
  output logic       draw_map,
  output logic       draw_char,
`ifdef LINK_CTRL_OVERRUN_EN
  output logic [7:0] overrun_cnt,
`endif
  output logic       busy
);

  localparam logic [8:0] DOWN_LIM  = 9'(MAP_H - SPRITE);
  localparam logic [8:0] RIGHT_LIM = 9'(MAP_W - SPRITE);

  state_t state_q, state_d;
  cmd_t   cmd_d;
  dir_t   dir_d;
  logic   pending, move_ok, locked;
  logic   decide, load_lock, armed;
  logic   up_ok, down_ok, left_ok, right_ok;

  logic init_q, init_d, idle_q, idle_d, attack_q, attack_d;
  logic move_up_q, move_up_d, move_down_q, move_down_d;
  logic move_left_q, move_left_d, move_right_q, move_right_d;
  logic draw_map_q, draw_map_d, draw_char_q, draw_char_d, busy_q, busy_d;

  assign up_ok    = btn_up && (link_y != 8'd0);
  assign down_ok  = btn_down && ({1'b0, link_y} < DOWN_LIM);
  assign left_ok  = btn_left && (link_x != 8'd0);
  assign right_ok = btn_right && ({1'b0, link_x} < RIGHT_LIM);

  assign decide    = (state_q == S_WAIT) && pending;
  assign load_lock = (state_q == S_DECIDE) && (cmd_d == CMD_ATTACK);
  assign armed     = (state_q != S_RESET);

  link_frame_pacer #(
    .MOVE_DIV     (MOVE_DIV),
    .ATTACK_FRAMES(ATTACK_FRAMES)
  ) u_pacer (
    .clock      (clock),
    .reset      (reset),
    .armed      (armed),
    .frame_tick (frame_tick),
    .decide     (decide),
    .load_lock  (load_lock),
`ifdef LINK_CTRL_OVERRUN_EN
    .overrun_cnt(overrun_cnt),
`endif
    .pending    (pending),
    .move_ok    (move_ok),
    .locked     (locked)
  );

  always_comb begin
    state_d = state_q;
    cmd_d   = CMD_IDLE;
    dir_d   = UP;
    case (state_q)
      S_RESET:     if (start) state_d = S_INIT;
      S_INIT:      state_d = S_DRAW_MAP;
      S_DRAW_MAP:  if (map_done) state_d = S_DRAW_CHAR;
      S_DRAW_CHAR: if (char_done) state_d = S_WAIT;
      S_WAIT:      if (pending) state_d = S_DECIDE;
      S_DECIDE: begin
        state_d = S_CMD;
        if (locked)          cmd_d = CMD_IDLE;
        else if (btn_attack) cmd_d = CMD_ATTACK;
        else if (!move_ok)   cmd_d = CMD_IDLE;
        else if (up_ok)    begin cmd_d = CMD_MOVE; dir_d = UP;    end
        else if (down_ok)  begin cmd_d = CMD_MOVE; dir_d = DOWN;  end
        else if (left_ok)  begin cmd_d = CMD_MOVE; dir_d = LEFT;  end
        else if (right_ok) begin cmd_d = CMD_MOVE; dir_d = RIGHT; end
      end
      S_CMD:       state_d = S_DRAW_MAP;
      default:     state_d = S_RESET;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the registered state.
  always_comb begin
    init_d       = (state_d == S_INIT);
    idle_d       = (state_d == S_WAIT) || ((state_d == S_CMD) && (cmd_d == CMD_IDLE));
    attack_d     = (state_d == S_CMD) && (cmd_d == CMD_ATTACK);
    move_up_d    = (state_d == S_CMD) && (cmd_d == CMD_MOVE) && (dir_d == UP);
    move_down_d  = (state_d == S_CMD) && (cmd_d == CMD_MOVE) && (dir_d == DOWN);
    move_left_d  = (state_d == S_CMD) && (cmd_d == CMD_MOVE) && (dir_d == LEFT);
    move_right_d = (state_d == S_CMD) && (cmd_d == CMD_MOVE) && (dir_d == RIGHT);
    draw_map_d   = (state_d == S_DRAW_MAP);
    draw_char_d  = (state_d == S_DRAW_CHAR);
    busy_d       = (state_d != S_RESET) && (state_d != S_WAIT);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_RESET;
      init_q       <= 1'b0;
      idle_q       <= 1'b0;
      attack_q     <= 1'b0;
      move_up_q    <= 1'b0;
      move_down_q  <= 1'b0;
      move_left_q  <= 1'b0;
      move_right_q <= 1'b0;
      draw_map_q   <= 1'b0;
      draw_char_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      init_q       <= init_d;
      idle_q       <= idle_d;
      attack_q     <= attack_d;
      move_up_q    <= move_up_d;
      move_down_q  <= move_down_d;
      move_left_q  <= move_left_d;
      move_right_q <= move_right_d;
      draw_map_q   <= draw_map_d;
      draw_char_q  <= draw_char_d;
      busy_q       <= busy_d;
    end
  end

  assign init       = init_q;
  assign idle       = idle_q;
  assign attack     = attack_q;
  assign move_up    = move_up_q;
  assign move_down  = move_down_q;
  assign move_left  = move_left_q;
  assign move_right = move_right_q;
  assign draw_map   = draw_map_q;
  assign draw_char  = draw_char_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_link_control.sv
// Directed bench for link_control with a frame-level reference model of the command rules.
module tb_link_control;

  localparam int MOVE_DIV = 2, ATTACK_FRAMES = 8, MAP_W = 256, MAP_H = 176, SPRITE = 16;
  localparam int C_IDLE = 0, C_ATTACK = 1, C_UP = 2, C_DOWN = 3, C_LEFT = 4, C_RIGHT = 5, C_NONE = 7;
  // outs = {init, idle, attack, up, down, left, right, draw_map, draw_char, busy}
  localparam logic [9:0] O_INIT = 10'b10_0000_0001;
  localparam logic [9:0] O_MAP  = 10'b00_0000_0101;
  localparam logic [9:0] O_CHAR = 10'b00_0000_0011;
  localparam logic [9:0] O_WAIT = 10'b01_0000_0000;

  logic clock = 1'b0;
  logic reset, start, btn_up, btn_down, btn_left, btn_right, btn_attack, frame_tick;
  logic [7:0] link_x, link_y;
  logic map_done, char_done;
  logic init, idle, attack, move_up, move_down, move_left, move_right, draw_map, draw_char, busy;
`ifdef LINK_CTRL_OVERRUN_EN
  logic [7:0] overrun_cnt;
`endif
  logic [9:0] outs;

  int passed = 0, total = 0;
  int map_delay = 3, char_delay = 0, stray_req = 0;
  int cyc = 0, dec_n = 0, last_att = -1000, exp_cmd = 0, onehot_bad = 0;
  bit prev_dec = 0;
  int cmd_log[$];
  int cmd_cyc[$];

  logic [4:0] t3_btn [11] = '{5'b00101, 5'b00101, 5'b00010, 5'b00010, 5'b01010, 5'b01010,
                              5'b00101, 5'b00101, 5'b00100, 5'b00100, 5'b00001};
  int t3_x [11] = '{240, 240, 0, 0, 50, 50, 50, 50, 50, 50, 239};
  int t3_y [11] = '{100, 100, 100, 100, 0, 0, 160, 160, 159, 159, 50};
  int t3_exp [11] = '{C_DOWN, C_IDLE, C_IDLE, C_IDLE, C_LEFT, C_IDLE,
                      C_RIGHT, C_IDLE, C_DOWN, C_IDLE, C_RIGHT};

  link_control #(.MOVE_DIV(MOVE_DIV), .ATTACK_FRAMES(ATTACK_FRAMES)) dut (
    .clock(clock), .reset(reset), .start(start),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .btn_attack(btn_attack), .frame_tick(frame_tick), .link_x(link_x), .link_y(link_y),
    .map_done(map_done), .char_done(char_done),
    .init(init), .idle(idle), .attack(attack), .move_up(move_up), .move_down(move_down),
    .move_left(move_left), .move_right(move_right), .draw_map(draw_map), .draw_char(draw_char),
`ifdef LINK_CTRL_OVERRUN_EN
    .overrun_cnt(overrun_cnt),
`endif
    .busy(busy)
  );

  assign outs = {init, idle, attack, move_up, move_down, move_left, move_right, draw_map, draw_char, busy};

  always #5 clock = ~clock;

  task automatic check(string name, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference rules, expressed per decision index rather than per cycle.
  function automatic int model_cmd(bit att, bit up, bit dn, bit lf, bit rt, int x, int y, int n, int la);
    if (n - la <= ATTACK_FRAMES) return C_IDLE;
    if (att) return C_ATTACK;
    if (n % MOVE_DIV != 0) return C_IDLE;
    if (up && y > 0) return C_UP;
    if (dn && y + SPRITE < MAP_H) return C_DOWN;
    if (lf && x > 0) return C_LEFT;
    if (rt && x + SPRITE < MAP_W) return C_RIGHT;
    return C_IDLE;
  endfunction

  function automatic int obs_cmd();
    if (attack) return C_ATTACK;
    if (move_up) return C_UP;
    if (move_down) return C_DOWN;
    if (move_left) return C_LEFT;
    if (move_right) return C_RIGHT;
    if (idle) return C_IDLE;
    return C_NONE;
  endfunction

  // Drawer stand-in: pulses done after the programmed delay, plus stray pulses on request.
  initial begin
    int map_wait, char_wait, stray_done;
    map_wait = 0; char_wait = 0; stray_done = 0;
    map_done = 1'b0; char_done = 1'b0;
    forever begin
      @(posedge clock); #2;
      map_done = 1'b0; char_done = 1'b0;
      if (draw_map) begin
        if (map_wait >= map_delay) begin map_done = 1'b1; map_wait = 0; end
        else map_wait++;
      end else map_wait = 0;
      if (draw_char) begin
        if (char_wait >= char_delay) begin char_done = 1'b1; char_wait = 0; end
        else char_wait++;
      end else char_wait = 0;
      if (stray_done != stray_req) begin char_done = 1'b1; stray_done = stray_req; end
    end
  end

  // Compare process: the cycle after DECIDE (busy, no strobe) must carry the model's command.
  always @(negedge clock) begin
    cyc++;
    if (reset) begin
      dec_n = 0; last_att = -1000; prev_dec = 0;
    end else begin
      if ($countones(outs[9:1]) > 1) onehot_bad++;
      if (prev_dec) begin
        check("decide_vs_model", obs_cmd(), exp_cmd);
        cmd_log.push_back(obs_cmd());
        cmd_cyc.push_back(cyc);
      end
      prev_dec = busy && (outs[9:1] == 9'd0);
      if (prev_dec) begin
        exp_cmd = model_cmd(btn_attack, btn_up, btn_down, btn_left, btn_right,
                            int'(link_x), int'(link_y), dec_n, last_att);
        if (exp_cmd == C_ATTACK) last_att = dec_n;
        dec_n++;
      end
    end
  end

  task automatic step(int n = 1);
    repeat (n) begin @(posedge clock); #2; end
  endtask

  task automatic wait_outs(string name, logic [9:0] want);
    int k;
    k = 0;
    while (outs != want && k < 2000) begin step(); k++; end
    check(name, int'(outs), int'(want));
  endtask

  task automatic pulse_tick(output int tcyc);
    frame_tick = 1'b1;
    tcyc = cyc + 1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic run_frame(string name, logic [4:0] b, int x, int y, int exp);
    int tc, n0, k;
    wait_outs({name, "_wait"}, O_WAIT);
    {btn_attack, btn_up, btn_down, btn_left, btn_right} = b;
    link_x = 8'(x);
    link_y = 8'(y);
    n0 = cmd_log.size();
    pulse_tick(tc);
    k = 0;
    while (cmd_log.size() == n0 && k < 50) begin step(); k++; end
    if (cmd_log.size() > n0) begin
      check(name, cmd_log[n0], exp);
      check({name, "_lat"}, cmd_cyc[n0] - tc, 3);
    end else check({name, "_nocmd"}, cmd_log.size(), n0 + 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int tc, n0, n1, bad;
    reset = 1'b1; start = 1'b0; frame_tick = 1'b0;
    {btn_attack, btn_up, btn_down, btn_left, btn_right} = 5'b0;
    link_x = 8'd100; link_y = 8'd80;
    step(3);
    check("reset_outs", int'(outs), 0);

    // Bring-up: init pulse, held map draw, char draw, then idle in WAIT.
    reset = 1'b0; start = 1'b1;
    step();
    check("init_pulse", int'(outs), int'(O_INIT));
    step();
    check("draw_map", int'(outs), int'(O_MAP));
    step();
    check("draw_map_hold", int'(outs), int'(O_MAP));
    wait_outs("draw_char", O_CHAR);
    wait_outs("idle_wait", O_WAIT);
    map_delay = 0;

    // Move-rate division with up held.
    run_frame("t2_f1", 5'b01000, 100, 80, C_UP);
    run_frame("t2_f2", 5'b01000, 100, 80, C_IDLE);
    run_frame("t2_f3", 5'b01000, 100, 80, C_UP);
    run_frame("t2_f4", 5'b01000, 100, 80, C_IDLE);

    // Edge blocking and fall-through.
    for (int i = 0; i < 11; i++)
      run_frame($sformatf("t3_%0d", i), t3_btn[i], t3_x[i], t3_y[i], t3_exp[i]);

    // Attack lockout: attack, eight idles, attack.
    for (int i = 0; i < 10; i++)
      run_frame($sformatf("t4_%0d", i), 5'b11000, 50, 50, (i == 0 || i == 9) ? C_ATTACK : C_IDLE);

    // Extra ticks during a slow map draw merge into one pending decision.
    map_delay = 100;
    wait_outs("t5_wait", O_WAIT);
    {btn_attack, btn_up, btn_down, btn_left, btn_right} = 5'b0;
    n0 = cmd_log.size();
    pulse_tick(tc);
    wait_outs("t5_map", O_MAP);
    step(5);
    pulse_tick(tc);
    step(10);
    pulse_tick(tc);
    n1 = cmd_log.size();
    check("t5_first_cmd", n1 - n0, 1);
    step(400);
    check("t5_one_decide", cmd_log.size() - n1, 1);
    check("t5_back_wait", int'(outs), int'(O_WAIT));
`ifdef LINK_CTRL_OVERRUN_EN
    check("t5_overrun", int'(overrun_cnt), 1);
`endif
    map_delay = 0;

    // Reset in the middle of a char draw; a late char_done must be ignored.
    start = 1'b0;
    char_delay = 50;
    pulse_tick(tc);
    wait_outs("t6_char", O_CHAR);
    step(3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t6_reset_outs", int'(outs), 0);
    stray_req++;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (outs != 10'd0) bad++;
    end
    check("t6_quiet", bad, 0);
`ifdef LINK_CTRL_OVERRUN_EN
    check("t6_overrun_clr", int'(overrun_cnt), 0);
`endif
    start = 1'b1;
    step();
    check("t6_restart", int'(outs), int'(O_INIT));
    step(2);

    check("onehot", onehot_bad, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/link_control.md
Name: link_control

Overview:
Game-loop controller for the player character, sitting directly upstream of the character movement/draw datapath.
- Converts debounced button inputs and a per-frame tick into one-hot command strobes: init, idle, attack, move_*, draw_map, draw_char.
- Sequences map redraw, then character redraw, once per frame, handshaking on the done signals returned by the map and character drawers.
- Enforces map-edge blocking, move-rate division and attack lockout.

Parameters:
MOVE_DIV, 2, frames per one-pixel move step (1..15)
ATTACK_FRAMES, 8, frames of move/attack lockout after an attack (1..15)
MAP_W, 256, map width in pixels
MAP_H, 176, map height in pixels
SPRITE, 16, character sprite edge in pixels

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
start  in  1  level; leaves S_RESET
btn_up, btn_down, btn_left, btn_right, btn_attack  in  1 each  synchronized, debounced, active-high levels
frame_tick  in  1  one-cycle pulse per video frame
link_x  in  8  current character x (top-left)
link_y  in  8  current character y (top-left)
map_done  in  1  one-cycle pulse, map redraw complete
char_done  in  1  one-cycle pulse, character redraw complete
init, idle, attack, move_up, move_down, move_left, move_right  out  1 each  command strobes
draw_map  out  1  level; map drawer active
draw_char  out  1  level; character drawer active
busy  out  1  high outside S_RESET and S_WAIT

Behaviour:
- All outputs are registered and decoded one-hot from state; at most one strobe is high per cycle. Reset drives every output to 0, state to S_RESET, and all counters and the pending flag to 0.
- Reset mid-draw behaves identically; done pulses arriving afterwards are ignored.
- States:
  - S_RESET: wait for start.
  - S_INIT: init=1 for one cycle.
  - S_DRAW_MAP: draw_map=1, hold until map_done.
  - S_DRAW_CHAR: draw_char=1, hold until char_done.
  - S_WAIT: idle=1, wait for the pending flag.
  - S_DECIDE: one cycle, no strobe; evaluates inputs.
  - S_CMD: exactly one of attack/move_*/idle high for one cycle.
- Transitions: RESET->INIT->DRAW_MAP->DRAW_CHAR->WAIT->DECIDE->CMD->DRAW_MAP.
- Frame pending flag:
  - Set on frame_tick in any state except S_RESET.
  - Cleared on entry to S_DECIDE.
  - frame_tick coinciding with that clear is retained, so the flag stays set.
- Latency: a frame_tick in S_WAIT produces the command strobe 3 cycles later (WAIT->DECIDE->CMD).
- Counters update on each S_DECIDE visit:
  - move_cnt increments, wrapping at MOVE_DIV-1.
  - lock_cnt decrements, saturating at 0.
- DECIDE priority:
  - If lock_cnt!=0, command is idle.
  - Else if btn_attack, command is attack and lock_cnt loads ATTACK_FRAMES.
  - Else if move_cnt!=0, command is idle.
  - Else the first of up>down>left>right pressed and not blocked is issued.
  - Else idle.
- Edge blocking:
  - up blocked when link_y==0.
  - down blocked when link_y>=MAP_H-SPRITE.
  - left blocked when link_x==0.
  - right blocked when link_x>=MAP_W-SPRITE.
  - A blocked direction falls through to the next priority.
- Simultaneous buttons: fixed priority only; no diagonal moves.
- Done pulse received in any state other than its own draw state: ignored.
- Comparisons are done in 9-bit to avoid wrap; MAP_H-SPRITE=160 and MAP_W-SPRITE=240 are constants.

Optional Feature:
LINK_CTRL_OVERRUN_EN
- With the macro: adds output overrun_cnt (8 bits). It increments, saturating at 255, on each frame_tick that arrives while the pending flag is already set and not being cleared that cycle. Reset clears it.
- Without the macro: the port is absent and extra ticks are silently merged.

Decomposition:
Package link_pkg holds:
- State encoding constants.
- Direction codes UP=2'b00, DOWN=2'b01, LEFT=2'b10, RIGHT=2'b11.
- MAP_W, MAP_H and SPRITE defaults.

Sub-module link_frame_pacer holds:
- Pending flag, move_cnt and lock_cnt.
- Optional overrun counter.
- Inputs: decide, load_lock. Outputs: pending, move_ok, locked.

Test Plan:
1. reset, start=1 → init pulse for 1 cycle, then draw_map. Assert map_done → draw_char. Assert char_done → idle=1, busy=0.
2. MOVE_DIV=2, link_y=80, btn_up held, 4 frame_ticks → move_up strobes in frames 1 and 3 only, each 3 cycles after the tick; idle strobes in frames 2 and 4.
3. link_x=240, btn_right and btn_down held, link_y=100 → move_down issued, never move_right. Repeat with link_x=0 and btn_left → idle strobe.
4. btn_attack plus btn_up, ATTACK_FRAMES=8 → attack strobe once. The next 8 decisions are idle despite buttons; the 9th is attack again.
5. Two frame_ticks during S_DRAW_MAP with map_done delayed 100 cycles → exactly one DECIDE afterwards. With LINK_CTRL_OVERRUN_EN, overrun_cnt=1.
6. reset asserted mid-S_DRAW_CHAR, then char_done → all outputs 0, state S_RESET, no draw or strobe until start.
